// File: rtl/sic_issue_queue_if.sv
// Issue-queue bus between an upstream decoder and the sub-SICs.
// Purpose: bundles the enqueue handshake, per-sub request/packet lanes,
//          flush and occupancy so the queue and its neighbours share one
//          definition of sic_packet_t.
// Signals: enq_valid/enq_ready/enq_pkt/enq_sub  enqueue handshake
//          sub_req[NUM_SUBS]                    per-sub req_instr
//          sub_pkt[NUM_SUBS]                    per-sub registered packet
//          flush                                discard everything queued
//          count                                occupied entries
// Modports: master = producer/consumer side, slave = the issue queue.
interface sic_issue_queue_if #(
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_ECRS     = 4,
  parameter int ID_WIDTH     = 8,
  parameter int DEPTH        = 4,
  parameter int NUM_SUBS     = 3
);
  localparam int PREG_W = (NUM_PHY_REGS > 1) ? $clog2(NUM_PHY_REGS) : 1;
  localparam int ECR_W  = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int SUB_W  = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ID_WIDTH-1:0] id;
    logic [PREG_W-1:0] dst;
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [ECR_W-1:0]  ecr;
  } sic_packet_t;

  logic                         enq_valid;
  logic                         enq_ready;
  sic_packet_t                  enq_pkt;
  logic [SUB_W-1:0]             enq_sub;
  logic [NUM_SUBS-1:0]          sub_req;
  sic_packet_t [NUM_SUBS-1:0]   sub_pkt;
  logic                         flush;
  logic [CNT_W-1:0]             count;

  modport master (
    output enq_valid, enq_pkt, enq_sub, sub_req, flush,
    input  enq_ready, sub_pkt, count
  );

  modport slave (
    input  enq_valid, enq_pkt, enq_sub, sub_req, flush,
    output enq_ready, sub_pkt, count
  );
endinterface

// File: rtl/sic_issue_queue.sv
// In-order issue buffer in front of the sub-SICs of one SIC.
// Purpose: queues decoded packets tagged with a target sub-unit and hands
//          the head packet to its sub-SIC as a one-cycle registered pulse
//          while that sub requests and is not already holding a pulse.
// Ports:   clk, rst_n (async active-low)
//          io (slave modport of sic_issue_queue_if): enqueue handshake,
//          per-sub req/packet lanes, flush, occupancy count.
module sic_issue_queue #(
  parameter int SIC_ID       = 0,
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_ECRS     = 4,
  parameter int ID_WIDTH     = 8,
  parameter int DEPTH        = 4,
  parameter int NUM_SUBS     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  sic_issue_queue_if.slave   io
);
  localparam int PREG_W = (NUM_PHY_REGS > 1) ? $clog2(NUM_PHY_REGS) : 1;
  localparam int ECR_W  = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int SUB_W  = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sic_issue_queue: DEPTH must be a power of two >= 2");
  end
  if (NUM_SUBS < 1) begin : g_bad_subs
    $error("sic_issue_queue: NUM_SUBS must be >= 1");
  end

  // Same layout as the interface packet so whole-packet assignments line up.
  typedef struct packed {
    logic              valid;
    logic [ID_WIDTH-1:0] id;
    logic [PREG_W-1:0] dst;
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [ECR_W-1:0]  ecr;
  } pkt_t;

  pkt_t [DEPTH-1:0]       mem_q, mem_d;
  logic [DEPTH-1:0][SUB_W-1:0] sub_mem_q, sub_mem_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  pkt_t [NUM_SUBS-1:0]    sub_pkt_q, sub_pkt_d;

  logic             enq_ready;
  logic             enq_fire;
  logic             enq_store;
  logic             deq_fire;
  logic             req_hit;
  logic             busy_hit;
  logic [SUB_W-1:0] head_sub;
  pkt_t             head_out;

  // Parameters/bits that exist only for debug or are deliberately ignored.
  logic unused_bits;
  assign unused_bits = io.enq_pkt.valid ^ SIC_ID[0];

  // Full is decided from the occupancy count only, never from a same-cycle dequeue.
  assign enq_ready    = (count_q != CNT_W'(DEPTH));
  assign io.enq_ready = enq_ready;
  assign io.count     = count_q;
  assign io.sub_pkt   = sub_pkt_q;

  // Next-state logic: enqueue into the tail, dispatch the head when its sub
  // requests and has no pulse in flight; flush overrides everything.
  always_comb begin
    mem_d     = mem_q;
    sub_mem_d = sub_mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    sub_pkt_d = '0;
    head_sub  = sub_mem_q[rd_ptr_q];
    head_out  = mem_q[rd_ptr_q];
    head_out.valid = 1'b1;
    req_hit   = 1'b0;
    busy_hit  = 1'b0;

    for (int i = 0; i < NUM_SUBS; i++) begin
      if (head_sub == SUB_W'(i)) begin
        req_hit  = io.sub_req[i];
        busy_hit = sub_pkt_q[i].valid;
      end
    end

    enq_fire  = io.enq_valid && enq_ready && !io.flush;
    // Out-of-range targets complete the handshake but are dropped on the floor.
    enq_store = enq_fire && ({1'b0, io.enq_sub} < (SUB_W + 1)'(NUM_SUBS));
    deq_fire  = (count_q != '0) && !io.flush && req_hit && !busy_hit;

    if (io.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_store) begin
        mem_d[wr_ptr_q]     = io.enq_pkt;
        sub_mem_d[wr_ptr_q] = io.enq_sub;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        for (int i = 0; i < NUM_SUBS; i++) begin
          if (head_sub == SUB_W'(i)) begin
            sub_pkt_d[i] = head_out;
          end
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq_store) - CNT_W'(deq_fire);
    end
  end

  // State register; entry storage is cleared too so reset leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      sub_mem_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      sub_pkt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      sub_mem_q <= sub_mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      sub_pkt_q <= sub_pkt_d;
    end
  end
endmodule

// File: tb/tb_sic_issue_queue.sv
// Directed self-checking bench for sic_issue_queue with a packet scoreboard.
module tb_sic_issue_queue;
  localparam int NUM_PHY_REGS = 64;
  localparam int NUM_ECRS     = 4;
  localparam int ID_WIDTH     = 8;
  localparam int DEPTH        = 4;
  localparam int NUM_SUBS     = 3;
  localparam int PREG_W       = 6;
  localparam int ECR_W        = 2;

  typedef struct packed {
    logic              valid;
    logic [ID_WIDTH-1:0] id;
    logic [PREG_W-1:0] dst;
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [ECR_W-1:0]  ecr;
  } tb_pkt_t;

  typedef struct {
    int      sub;
    tb_pkt_t pkt;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  sb_entry_t sb[$];
  logic [NUM_SUBS-1:0] mask;
  logic [NUM_SUBS-1:0] prev_mask;

  sic_issue_queue_if #(
    .NUM_PHY_REGS(NUM_PHY_REGS), .NUM_ECRS(NUM_ECRS), .ID_WIDTH(ID_WIDTH),
    .DEPTH(DEPTH), .NUM_SUBS(NUM_SUBS)
  ) bus ();

  sic_issue_queue #(
    .SIC_ID(0), .NUM_PHY_REGS(NUM_PHY_REGS), .NUM_ECRS(NUM_ECRS),
    .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH), .NUM_SUBS(NUM_SUBS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tb_pkt_t mk(input int id);
    tb_pkt_t p;
    p.valid = id[0];
    p.id    = id[7:0];
    p.dst   = 6'(id * 3);
    p.src1  = 6'(id + 1);
    p.src2  = 6'(id + 7);
    p.ecr   = 2'(id);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int id, input logic [1:0] sub,
                               input logic [NUM_SUBS-1:0] req, input logic fl);
    bus.enq_valid = v;
    bus.enq_pkt   = mk(id);
    bus.enq_sub   = sub;
    bus.sub_req   = req;
    bus.flush     = fl;
  endtask

  task automatic expectPkt(input int id, input int sub);
    sb_entry_t e;
    e.sub       = sub;
    e.pkt       = mk(id);
    e.pkt.valid = 1'b1;
    sb.push_back(e);
  endtask

  // Samples every sub lane, pops the scoreboard for each pulse seen.
  task automatic checkOutput();
    sb_entry_t e;
    for (int i = 0; i < NUM_SUBS; i++) begin
      mask[i] = bus.sub_pkt[i].valid;
      if (bus.sub_pkt[i].valid) begin
        chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
        chk("pulse_width", 32'(prev_mask[i]), 32'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pulse_sub", 32'(i), 32'(e.sub));
          chk("pulse_pkt", 32'(bus.sub_pkt[i]), 32'(e.pkt));
        end
      end else begin
        chk("idle_lane_zero", 32'(bus.sub_pkt[i]), 32'd0);
      end
    end
    chk("one_dispatch", 32'($countones(mask) <= 1), 32'd1);
    prev_mask = mask;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int exp_mask [4];
    errors    = 0;
    checks    = 0;
    prev_mask = '0;
    mask      = '0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, 0, 2'd0, 3'b000, 1'b0);
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.enq_ready), 32'd1);
    chk("rst_subpkt", 32'(bus.sub_pkt), 32'd0);
    rst_n = 1'b1;

    // Single packet: enqueue edge, then pulse on the following edge only.
    applyStimulus(1'b1, 1, 2'd0, 3'b001, 1'b0);
    expectPkt(1, 0);
    step();
    chk("t1_count_after_enq", 32'(bus.count), 32'd1);
    chk("t1_no_bypass", 32'(mask), 32'd0);
    applyStimulus(1'b0, 0, 2'd0, 3'b001, 1'b0);
    step();
    chk("t1_pulse", 32'(mask), 32'b001);
    chk("t1_count_after_deq", 32'(bus.count), 32'd0);
    step();
    chk("t1_pulse_ends", 32'(mask), 32'd0);

    // Fill past DEPTH with no requests; the fifth offer is refused.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 10 + k, 2'(k % 3), 3'b000, 1'b0);
      if (k < 4) expectPkt(10 + k, k % 3);
      step();
      chk("t2_count_fill", 32'(bus.count), 32'((k < 4) ? k + 1 : 4));
    end
    chk("t2_full_ready", 32'(bus.enq_ready), 32'd0);
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_drain_mask", 32'(mask), 32'(1 << (k % 3)));
      chk("t2_drain_count", 32'(bus.count), 32'(3 - k));
    end
    step();
    chk("t2_idle", 32'(mask), 32'd0);

    // Two packets for one sub: the second waits while the first pulse is up.
    applyStimulus(1'b1, 40, 2'd2, 3'b000, 1'b0);
    expectPkt(40, 2);
    step();
    applyStimulus(1'b1, 41, 2'd2, 3'b000, 1'b0);
    expectPkt(41, 2);
    step();
    chk("t2b_count", 32'(bus.count), 32'd2);
    applyStimulus(1'b0, 0, 2'd0, 3'b100, 1'b0);
    step();
    chk("t2b_first", 32'(mask), 32'b100);
    step();
    chk("t2b_gap", 32'(mask), 32'd0);
    chk("t2b_gap_count", 32'(bus.count), 32'd1);
    step();
    chk("t2b_second", 32'(mask), 32'b100);
    chk("t2b_count_end", 32'(bus.count), 32'd0);

    // Head-of-line blocking: head targets sub1 which is not requesting.
    applyStimulus(1'b1, 50, 2'd1, 3'b001, 1'b0);
    expectPkt(50, 1);
    step();
    applyStimulus(1'b1, 51, 2'd0, 3'b001, 1'b0);
    expectPkt(51, 0);
    step();
    applyStimulus(1'b0, 0, 2'd0, 3'b001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_blocked", 32'(mask), 32'd0);
      chk("t3_blocked_count", 32'(bus.count), 32'd2);
    end
    applyStimulus(1'b0, 0, 2'd0, 3'b011, 1'b0);
    step();
    chk("t3_head_sub1", 32'(mask), 32'b010);
    step();
    chk("t3_next_sub0", 32'(mask), 32'b001);
    step();
    chk("t3_idle", 32'(mask), 32'd0);

    // Full queue with a dispatchable head: no same-cycle enqueue look-ahead.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 20 + k, 2'(k % 3), 3'b000, 1'b0);
      expectPkt(20 + k, k % 3);
      step();
    end
    chk("t4_full", 32'(bus.count), 32'd4);
    applyStimulus(1'b1, 24, 2'd1, 3'b001, 1'b0);
    expectPkt(24, 1);
    step();
    chk("t4_refused_count", 32'(bus.count), 32'd3);
    chk("t4_head_out", 32'(mask), 32'b001);
    step();
    chk("t4_accepted_count", 32'(bus.count), 32'd4);
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    exp_mask = '{2, 4, 1, 2};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_drain_mask", 32'(mask), 32'(exp_mask[k]));
    end
    chk("t4_empty", 32'(bus.count), 32'd0);

    // Flush beats a same-cycle enqueue and dispatch.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 30 + k, 2'(k), 3'b000, 1'b0);
      step();
    end
    chk("t5_count3", 32'(bus.count), 32'd3);
    applyStimulus(1'b1, 33, 2'd0, 3'b111, 1'b1);
    step();
    chk("t5_flush_count", 32'(bus.count), 32'd0);
    chk("t5_flush_mask", 32'(mask), 32'd0);
    chk("t5_flush_ready", 32'(bus.enq_ready), 32'd1);
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_late_pulse", 32'(mask), 32'd0);
    end

    // Out-of-range target: accepted, never stored, pointers stay aligned.
    applyStimulus(1'b1, 60, 2'd3, 3'b111, 1'b0);
    chk("t6_ready", 32'(bus.enq_ready), 32'd1);
    step();
    chk("t6_count", 32'(bus.count), 32'd0);
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    step();
    chk("t6_no_pulse", 32'(mask), 32'd0);
    applyStimulus(1'b1, 61, 2'd2, 3'b111, 1'b0);
    expectPkt(61, 2);
    step();
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    step();
    chk("t6_follow_pulse", 32'(mask), 32'b100);

    // Asynchronous reset mid-operation.
    applyStimulus(1'b1, 70, 2'd0, 3'b000, 1'b0);
    step();
    applyStimulus(1'b1, 71, 2'd1, 3'b000, 1'b0);
    step();
    applyStimulus(1'b0, 0, 2'd0, 3'b000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_count", 32'(bus.count), 32'd0);
    chk("t7_async_ready", 32'(bus.enq_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    prev_mask = '0;
    applyStimulus(1'b0, 0, 2'd0, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t7_no_pulse", 32'(mask), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
